// File: rtl/dfq_pkg.sv
// dfq_pkg: shared state encoding, defaults and width helper for the DFQ dequeue path.
package dfq_pkg;
  typedef enum logic [1:0] {IDLE, PUSH, WAIT, FINISH} dq_state_e;
  localparam int TAIL_BIT_DEF = 15;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/dq_lat_timer.sv
// dq_lat_timer: loadable down-counter flagging the final pointer-RAM wait cycle.
module dq_lat_timer #(
  parameter int RAM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic fin
);
  logic [2:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= 3'(RAM_LAT);
    else if (cnt != '0) cnt <= cnt - 3'd1;
  assign fin = cnt == '0;
endmodule

// File: rtl/dequeue_walker.sv
// dequeue_walker: walks a frame's cell-pointer list and pushes each pointer into a per-PCP queue.
module dequeue_walker import dfq_pkg::*; #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_Q      = 8,
  parameter int RAM_LAT    = 1,
  parameter int TAIL_BIT   = TAIL_BIT_DEF,
  parameter int MAX_CELLS  = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_dequeue,
  input  logic [clog2(NUM_Q)-1:0]   dq_qid,
  input  logic [DATA_WIDTH-1:0]     head_ptr_in,
  output logic                      busy,
  output logic                      ptr_ram_rd,
  output logic [ADDR_WIDTH-1:0]     ptr_ram_addr,
  input  logic [DATA_WIDTH-1:0]     ptr_ram_dout,
  input  logic [NUM_Q-1:0]          pcp_queue_full,
  output logic [NUM_Q-1:0]          pcp_queue_wr,
  output logic [DATA_WIDTH-1:0]     pcp_queue_din,
  output logic [DATA_WIDTH-1:0]     new_head,
  output logic                      dequeue_done,
  output logic [clog2(NUM_Q)-1:0]   done_qid,
  output logic [15:0]               rd_depth_cell,
  output logic                      err_overrun,
  output logic                      err_badqid
);
  localparam int QW = clog2(NUM_Q);
  dq_state_e state;
  logic [DATA_WIDTH-1:0] cur, nxt;
  logic [QW-1:0] qid;
  logic last, ovr, lat_fin, bad_qid;
  assign bad_qid = {1'b0, dq_qid} >= (QW+1)'(NUM_Q);
  dq_lat_timer #(.RAM_LAT(RAM_LAT)) u_lat (
    .clk(clk),
    .reset(reset),
    .load(state == PUSH && !pcp_queue_full[qid]),
    .fin(lat_fin)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state         <= IDLE;
      cur           <= '0;
      nxt           <= '0;
      qid           <= '0;
      last          <= 1'b0;
      ovr           <= 1'b0;
      busy          <= 1'b0;
      ptr_ram_rd    <= 1'b0;
      ptr_ram_addr  <= '0;
      pcp_queue_wr  <= '0;
      pcp_queue_din <= '0;
      new_head      <= '0;
      dequeue_done  <= 1'b0;
      done_qid      <= '0;
      rd_depth_cell <= '0;
      err_overrun   <= 1'b0;
      err_badqid    <= 1'b0;
    end else begin
      ptr_ram_rd   <= 1'b0;
      pcp_queue_wr <= '0;
      dequeue_done <= 1'b0;
      err_overrun  <= 1'b0;
      err_badqid   <= 1'b0;
      case (state)
        IDLE: if (start_dequeue) begin
          if (bad_qid) err_badqid <= 1'b1;
          else begin
            cur           <= head_ptr_in;
            qid           <= dq_qid;
            rd_depth_cell <= '0;
            ovr           <= 1'b0;
            busy          <= 1'b1;
            state         <= PUSH;
          end
        end
        PUSH: if (!pcp_queue_full[qid]) begin
          pcp_queue_wr[qid] <= 1'b1;
          pcp_queue_din     <= cur;
          ptr_ram_rd        <= 1'b1;
          ptr_ram_addr      <= cur[ADDR_WIDTH-1:0];
          rd_depth_cell     <= rd_depth_cell + {15'd0, rd_depth_cell != '1};
          last              <= cur[TAIL_BIT];
          state             <= WAIT;
        end
        WAIT: if (lat_fin) begin
          nxt <= ptr_ram_dout;
          if (last) state <= FINISH;
          else if (rd_depth_cell == 16'(MAX_CELLS)) begin
            ovr   <= 1'b1;
            state <= FINISH;
          end else begin
            cur   <= ptr_ram_dout;
            state <= PUSH;
          end
        end
        FINISH: begin
          if (!ovr) new_head <= nxt;
          dequeue_done <= 1'b1;
          done_qid     <= qid;
          err_overrun  <= ovr;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dequeue_walker.sv
// tb_dequeue_walker: directed edge-accurate checks of the dequeue walker at RAM_LAT 1 and 3.
module tb_dequeue_walker;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, sel = 1'b0;
  logic [2:0] qid_in = '0;
  logic [19:0] head_in = '0;
  logic [7:0] full_v = '0;
  logic a_busy, a_rd, a_done, a_ovr, a_bad, b_busy, b_rd, b_done, b_ovr, b_bad;
  logic [9:0] a_addr, b_addr;
  logic [19:0] a_dout, b_dout, a_din, b_din, a_nh, b_nh;
  logic [7:0] a_wr, b_wr;
  logic [2:0] a_dq, b_dq;
  logic [15:0] a_dep, b_dep;
  logic [19:0] mem [0:1023];
  logic [19:0] bp [3];
  int cyc = 0, pass = 0, total = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) a_dout <= a_rd ? mem[a_addr] : '0;
  always @(posedge clk) begin
    bp[0] <= b_rd ? mem[b_addr] : '0;
    bp[1] <= bp[0];
    bp[2] <= bp[1];
  end
  assign b_dout = bp[2];
  dequeue_walker #(.RAM_LAT(1), .MAX_CELLS(4)) dut_a (
    .clk(clk), .reset(reset), .start_dequeue(start & ~sel), .dq_qid(qid_in), .head_ptr_in(head_in),
    .busy(a_busy), .ptr_ram_rd(a_rd), .ptr_ram_addr(a_addr), .ptr_ram_dout(a_dout),
    .pcp_queue_full(full_v), .pcp_queue_wr(a_wr), .pcp_queue_din(a_din), .new_head(a_nh),
    .dequeue_done(a_done), .done_qid(a_dq), .rd_depth_cell(a_dep), .err_overrun(a_ovr), .err_badqid(a_bad)
  );
  dequeue_walker #(.RAM_LAT(3), .MAX_CELLS(64)) dut_b (
    .clk(clk), .reset(reset), .start_dequeue(start & sel), .dq_qid(qid_in), .head_ptr_in(head_in),
    .busy(b_busy), .ptr_ram_rd(b_rd), .ptr_ram_addr(b_addr), .ptr_ram_dout(b_dout),
    .pcp_queue_full(full_v), .pcp_queue_wr(b_wr), .pcp_queue_din(b_din), .new_head(b_nh),
    .dequeue_done(b_done), .done_qid(b_dq), .rd_depth_cell(b_dep), .err_overrun(b_ovr), .err_badqid(b_bad)
  );
  logic [7:0] o_wr;
  logic [19:0] o_din, o_nh;
  logic o_done, o_ovr, o_busy;
  logic [2:0] o_dq;
  logic [15:0] o_dep;
  assign o_wr   = sel ? b_wr : a_wr;
  assign o_din  = sel ? b_din : a_din;
  assign o_nh   = sel ? b_nh : a_nh;
  assign o_done = sel ? b_done : a_done;
  assign o_ovr  = sel ? b_ovr : a_ovr;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_dq   = sel ? b_dq : a_dq;
  assign o_dep  = sel ? b_dep : a_dep;
  int nwr, done_e;
  int wr_e [8];
  logic [19:0] wr_d [8];
  logic [7:0] wr_v [8];
  logic [2:0] r_dq;
  logic [15:0] r_dep;
  logic [19:0] r_nh;
  logic r_ovr, r_busy;
  // Edge numbers are relative to the start edge (edge 0); sampling is on the falling edge.
  task automatic walk(input logic s, input logic [2:0] q, input logic [19:0] h,
                      input int st_lo, input int st_hi, input int ign_at);
    int e0, r;
    nwr = 0;
    done_e = -1;
    @(negedge clk);
    sel = s; qid_in = q; head_in = h; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
    for (int i = 0; i < 200 && done_e < 0; i++) begin
      r = cyc - e0;
      if (o_wr !== '0 && nwr < 8) begin
        wr_e[nwr] = r; wr_d[nwr] = o_din; wr_v[nwr] = o_wr; nwr++;
      end
      if (o_done === 1'b1) begin
        done_e = r; r_dq = o_dq; r_dep = o_dep; r_nh = o_nh; r_ovr = o_ovr; r_busy = o_busy;
      end
      full_v = (r >= st_lo && r < st_hi) ? 8'h20 : 8'h00;
      start = (r == ign_at);
      if (r == ign_at) begin qid_in = 3'd6; head_in = 20'h08040; end
      if (done_e < 0) @(negedge clk);
    end
    full_v = '0;
    start = 1'b0;
  endtask
  task automatic test_reset;
    @(negedge clk);
    total++; if ({a_busy, a_rd, a_addr, a_wr, a_din, a_nh, a_done, a_dq, a_dep, a_ovr, a_bad} !== '0)
      $display("FAIL reset_a got busy=%b wr=%h nh=%h dep=%0d exp all zero", a_busy, a_wr, a_nh, a_dep); else pass++;
    total++; if ({b_busy, b_rd, b_addr, b_wr, b_din, b_nh, b_done, b_dq, b_dep, b_ovr, b_bad} !== '0)
      $display("FAIL reset_b got busy=%b wr=%h nh=%h dep=%0d exp all zero", b_busy, b_wr, b_nh, b_dep); else pass++;
  endtask
  task automatic test_three_cell;
    logic [19:0] exp_d [3];
    exp_d = '{20'h00010, 20'h00020, 20'h08030};
    walk(1'b0, 3'd2, 20'h00010, -1, -1, -1);
    total++; if (nwr !== 3) $display("FAIL three_nwr got %0d exp 3", nwr); else pass++;
    for (int k = 0; k < 3; k++) begin
      total++; if (wr_e[k] !== 1 + 3 * k) $display("FAIL three_edge%0d got %0d exp %0d", k, wr_e[k], 1 + 3 * k); else pass++;
      total++; if (wr_v[k] !== 8'h04 || wr_d[k] !== exp_d[k])
        $display("FAIL three_push%0d got wr=%h din=%h exp wr=04 din=%h", k, wr_v[k], wr_d[k], exp_d[k]); else pass++;
    end
    total++; if (done_e !== 10) $display("FAIL three_done_edge got %0d exp 10", done_e); else pass++;
    total++; if (r_dep !== 16'd3 || r_nh !== 20'h00555 || r_dq !== 3'd2 || r_ovr !== 1'b0)
      $display("FAIL three_result got dep=%0d nh=%h qid=%0d ovr=%b exp dep=3 nh=00555 qid=2 ovr=0", r_dep, r_nh, r_dq, r_ovr); else pass++;
    repeat (3) @(negedge clk);
    total++; if (a_dep !== 16'd3 || a_nh !== 20'h00555 || a_done !== 1'b0)
      $display("FAIL three_hold got dep=%0d nh=%h done=%b exp dep=3 nh=00555 done=0", a_dep, a_nh, a_done); else pass++;
  endtask
  task automatic test_single;
    walk(1'b0, 3'd1, 20'h08040, -1, -1, -1);
    total++; if (nwr !== 1 || wr_e[0] !== 1 || wr_v[0] !== 8'h02 || wr_d[0] !== 20'h08040)
      $display("FAIL single_push got n=%0d edge=%0d wr=%h din=%h exp n=1 edge=1 wr=02 din=08040", nwr, wr_e[0], wr_v[0], wr_d[0]); else pass++;
    total++; if (done_e !== 4) $display("FAIL single_done_edge got %0d exp 4", done_e); else pass++;
    total++; if (r_dep !== 16'd1 || r_nh !== 20'h00777)
      $display("FAIL single_result got dep=%0d nh=%h exp dep=1 nh=00777", r_dep, r_nh); else pass++;
  endtask
  task automatic test_stall;
    logic [19:0] exp_d [3];
    int exp_e [3];
    exp_d = '{20'h00010, 20'h00020, 20'h08030};
    exp_e = '{1, 10, 13};
    walk(1'b0, 3'd5, 20'h00010, 3, 9, -1);
    total++; if (nwr !== 3) $display("FAIL stall_nwr got %0d exp 3", nwr); else pass++;
    for (int k = 0; k < 3; k++) begin
      total++; if (wr_e[k] !== exp_e[k] || wr_v[k] !== 8'h20 || wr_d[k] !== exp_d[k])
        $display("FAIL stall_push%0d got edge=%0d wr=%h din=%h exp edge=%0d wr=20 din=%h", k, wr_e[k], wr_v[k], wr_d[k], exp_e[k], exp_d[k]); else pass++;
    end
    total++; if (done_e !== 16 || r_dep !== 16'd3)
      $display("FAIL stall_done got edge=%0d dep=%0d exp edge=16 dep=3", done_e, r_dep); else pass++;
  endtask
  task automatic test_overrun;
    walk(1'b0, 3'd0, 20'h00100, -1, -1, -1);
    total++; if (nwr !== 4) $display("FAIL ovr_nwr got %0d exp 4", nwr); else pass++;
    for (int k = 0; k < 4; k++) begin
      total++; if (wr_d[k] !== 20'h00100 + 20'(k) || wr_v[k] !== 8'h01)
        $display("FAIL ovr_push%0d got wr=%h din=%h exp wr=01 din=%h", k, wr_v[k], wr_d[k], 20'h00100 + 20'(k)); else pass++;
    end
    total++; if (done_e !== 13 || r_ovr !== 1'b1 || r_dep !== 16'd4)
      $display("FAIL ovr_done got edge=%0d ovr=%b dep=%0d exp edge=13 ovr=1 dep=4", done_e, r_ovr, r_dep); else pass++;
    total++; if (r_nh !== 20'h00555) $display("FAIL ovr_new_head got %h exp 00555", r_nh); else pass++;
  endtask
  task automatic test_busy_ignore;
    int bad;
    walk(1'b0, 3'd2, 20'h00010, -1, -1, 2);
    total++; if (nwr !== 3 || wr_v[0] !== 8'h04 || wr_v[1] !== 8'h04 || wr_v[2] !== 8'h04 || wr_d[1] !== 20'h00020)
      $display("FAIL busy_pushes got n=%0d wr1=%h din1=%h exp n=3 wr=04 din1=00020", nwr, wr_v[1], wr_d[1]); else pass++;
    total++; if (done_e !== 10 || r_dq !== 3'd2 || r_nh !== 20'h00555 || r_busy !== 1'b0)
      $display("FAIL busy_done got edge=%0d qid=%0d nh=%h busy=%b exp edge=10 qid=2 nh=00555 busy=0", done_e, r_dq, r_nh, r_busy); else pass++;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_wr !== '0 || a_done !== 1'b0 || a_busy !== 1'b0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL busy_after got %0d active cycles exp 0", bad); else pass++;
  endtask
  task automatic test_reset_mid;
    int bad;
    @(negedge clk);
    sel = 1'b0; qid_in = 3'd3; head_in = 20'h00010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if ({a_busy, a_rd, a_wr, a_din, a_nh, a_done, a_dq, a_dep, a_ovr} !== '0)
      $display("FAIL rstmid_zero got busy=%b nh=%h dep=%0d exp all zero", a_busy, a_nh, a_dep); else pass++;
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (a_wr !== '0 || a_rd !== 1'b0 || a_done !== 1'b0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL rstmid_quiet got %0d active cycles exp 0", bad); else pass++;
    walk(1'b0, 3'd1, 20'h08040, -1, -1, -1);
    total++; if (done_e !== 4 || r_dep !== 16'd1 || r_nh !== 20'h00777 || r_dq !== 3'd1)
      $display("FAIL rstmid_restart got edge=%0d dep=%0d nh=%h qid=%0d exp edge=4 dep=1 nh=00777 qid=1", done_e, r_dep, r_nh, r_dq); else pass++;
  endtask
  task automatic test_lat3;
    walk(1'b1, 3'd4, 20'h00200, -1, -1, -1);
    total++; if (nwr !== 2 || wr_e[0] !== 1 || wr_e[1] !== 6)
      $display("FAIL lat3_edges got n=%0d e0=%0d e1=%0d exp n=2 e0=1 e1=6", nwr, wr_e[0], wr_e[1]); else pass++;
    total++; if (wr_v[0] !== 8'h10 || wr_d[0] !== 20'h00200 || wr_d[1] !== 20'h08210)
      $display("FAIL lat3_push got wr=%h d0=%h d1=%h exp wr=10 d0=00200 d1=08210", wr_v[0], wr_d[0], wr_d[1]); else pass++;
    total++; if (done_e !== 11 || r_nh !== 20'h00999 || r_dep !== 16'd2)
      $display("FAIL lat3_done got edge=%0d nh=%h dep=%0d exp edge=11 nh=00999 dep=2", done_e, r_nh, r_dep); else pass++;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h010] = 20'h00020;
    mem[10'h020] = 20'h08030;
    mem[10'h030] = 20'h00555;
    mem[10'h040] = 20'h00777;
    for (int i = 0; i < 5; i++) mem[10'h100 + i] = 20'h00101 + 20'(i);
    mem[10'h200] = 20'h08210;
    mem[10'h210] = 20'h00999;
    repeat (2) @(negedge clk);
    test_reset;
    reset = 1'b0;
    test_three_cell;
    test_single;
    test_stall;
    test_overrun;
    test_busy_ignore;
    test_reset_mid;
    test_lat3;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/dequeue_walker.md
# dequeue_walker

Parametrised successor of the single-queue frame dequeue engine in the DFQ CAM datapath. It walks one frame's cell-pointer linked list in pointer RAM and pushes every cell pointer into one of `NUM_Q` per-PCP output queues, honouring per-queue backpressure. It returns the next frame's head pointer to the CAM/scheduler and reports the cell count. It sits between the ATS/scheduler (issues `start_dequeue` with a target queue) and the PCP queue FIFOs.

## Interface
- `DATA_WIDTH`, 20: pointer word width.
- `ADDR_WIDTH`, 10: pointer-RAM address width; address = `word[ADDR_WIDTH-1:0]`.
- `NUM_Q`, 8: number of PCP output queues, power of two, ≥2.
- `RAM_LAT`, 1: pointer-RAM read latency in cycles, 1..4.
- `TAIL_BIT`, 15: set in a word → that cell is the frame's last cell.
- `MAX_CELLS`, 64: walk limit, ≤65535.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `start_dequeue` in 1: request, one-cycle pulse; accepted only when `busy`=0.
- `dq_qid` in log2(NUM_Q): target queue, sampled with start.
- `head_ptr_in` in DATA_WIDTH: frame head word, sampled with start.
- `busy` out 1: high from the accept edge until `dequeue_done` is visible.
- `ptr_ram_rd` out 1: one-cycle read strobe.
- `ptr_ram_addr` out ADDR_WIDTH: read address.
- `ptr_ram_dout` in DATA_WIDTH: read data, valid `RAM_LAT` cycles after `ptr_ram_rd`.
- `pcp_queue_full` in NUM_Q: per-queue full.
- `pcp_queue_wr` out NUM_Q: one-hot write strobe.
- `pcp_queue_din` out DATA_WIDTH: pushed word, shared by all queues.
- `new_head` out DATA_WIDTH: successor word of the last cell, i.e. the next frame head; held until the next done.
- `dequeue_done` out 1: one-cycle completion pulse.
- `done_qid` out log2(NUM_Q): qid of the completed walk, valid with done.
- `rd_depth_cell` out 16: cells pushed in the current or last walk.
- `err_overrun` out 1: pulse with done when `MAX_CELLS` is reached without a tail.
- `err_badqid` out 1: pulse when start is rejected for `dq_qid`≥NUM_Q. Reachable only if NUM_Q is changed to a non-power-of-two; otherwise tie-off.

## Operation
- Reset values:
  - All outputs 0, state IDLE.
  - Internal current-word and qid registers 0.
- All outputs are registered.
- IDLE:
  - On start with `busy`=0: latch `cur`←`head_ptr_in` and `qid`←`dq_qid`, clear `rd_depth_cell`, raise `busy`, go to PUSH.
  - Start while busy is ignored, with no side effects.
- PUSH:
  - If `pcp_queue_full[qid]`: stay, no strobes.
  - Else, in the same edge:
    - `pcp_queue_wr[qid]`←1, `pcp_queue_din`←`cur`.
    - `ptr_ram_rd`←1, `ptr_ram_addr`←`cur[ADDR_WIDTH-1:0]`.
    - `rd_depth_cell`+1.
    - `last`←`cur[TAIL_BIT]`.
    - Go to WAIT.
- WAIT: lasts exactly `RAM_LAT`+1 cycles, timed by a lat counter. On its final edge `nxt`←`ptr_ram_dout`, then:
  - If `last`: go to FINISH.
  - Else if `rd_depth_cell`==`MAX_CELLS`: go to FINISH with the overrun flag set.
  - Else `cur`←`nxt`, go to PUSH.
- FINISH (1 cycle):
  - `new_head`←`nxt` (on overrun, `new_head` is left unchanged).
  - `dequeue_done`←1, `done_qid`←`qid`, `err_overrun`←overrun flag.
  - Clear `busy`, go to IDLE.
- A single-cell frame is the head word with `TAIL_BIT` set: one push, one read.
- `rd_depth_cell` saturates at 16 bits and holds its value after done until the next accept.
- Reset mid-walk abandons the walk: no done, and no further strobes after reset deasserts.

## Timing
- Per cell: 2+`RAM_LAT` cycles with no backpressure. Each full cycle in PUSH adds 1.
- With the start edge as edge 0:
  - The k-th (0-based) write strobe is registered on edge 1+k·(2+`RAM_LAT`).
  - `dequeue_done` is registered on edge 1+N·(2+`RAM_LAT`) for an N-cell frame.
- Next start can be accepted on the edge after done is visible.
- `pcp_queue_full` is sampled in PUSH before the write. The queue must assert full with ≥1 free entry of slack, because the write is visible one cycle after sampling.

## Structure
- Shared package `dfq_pkg`:
  - State enum (IDLE, PUSH, WAIT, FINISH).
  - `TAIL_BIT` default.
  - qid width function `clog2`.
- One sub-module, `dq_lat_timer`: loadable down-counter that flags the final WAIT cycle for `RAM_LAT`+1.

## Test plan
- 3-cell frame, `RAM_LAT`=1, qid 2, no backpressure:
  - `pcp_queue_wr`=8'h04 on edges 1, 4, 7.
  - `dequeue_done` on edge 10, `rd_depth_cell`=3, `new_head`= RAM word at the tail address.
- Single-cell head with bit15 set → one write, done on edge 4, `rd_depth_cell`=1.
- `pcp_queue_full[5]` held high for 6 cycles mid-walk on qid 5 → no writes during the stall, done delayed by exactly 6 cycles, all cells pushed in order.
- Chain with no tail, `MAX_CELLS`=4:
  - Exactly 4 writes.
  - `dequeue_done`+`err_overrun` on the same cycle, `new_head` unchanged.
- `RAM_LAT`=3 build, 2-cell frame → done on edge 11.
- Start while busy is ignored; reset asserted mid-walk → all outputs 0 and no done; a new start afterwards completes normally.
